// File: rtl/parallel_to_serial_if.sv
// Word-in / bit-out bus of the serializer: parallel handshake on one side,
// serial bit stream plus status on the other.
interface parallel_to_serial_if #(
  parameter int DEPTH = 3
);
  logic [DEPTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             hold;
  logic             serial_out;
  logic             serial_en;
  logic             busy;
  logic             word_done;

  modport master (
    output in_data,
    output in_valid,
    output hold,
    input  in_ready,
    input  serial_out,
    input  serial_en,
    input  busy,
    input  word_done
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  hold,
    output in_ready,
    output serial_out,
    output serial_en,
    output busy,
    output word_done
  );
endinterface

// File: rtl/parallel_to_serial.sv
// MSB-first serializer: accepts a DEPTH-bit word on valid/ready and shifts it out
// one bit per clock, reloading on the last bit so consecutive words have no gap.
module parallel_to_serial #(
  parameter int DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  parallel_to_serial_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_p0, state_nxt;
  logic [DEPTH-1:0] shreg_p0, shreg_nxt;
  logic [CNT_W-1:0] cnt_p0, cnt_nxt;
  logic             done_p0, done_nxt;
  logic             last_bit;
  logic             fire;

  // cnt holds bits remaining minus one, so zero marks the final bit on the wire
  assign last_bit       = (cnt_p0 == '0);
  assign bus.serial_en  = (state_p0 == SHIFT) && !bus.hold;
  assign bus.in_ready   = (state_p0 == IDLE) || ((state_p0 == SHIFT) && last_bit && !bus.hold);
  assign fire           = bus.in_valid && bus.in_ready;
  assign bus.serial_out = shreg_p0[DEPTH-1];
  assign bus.busy       = (state_p0 == SHIFT);
  assign bus.word_done  = done_p0;

  always_comb begin
    state_nxt = state_p0;
    shreg_nxt = shreg_p0;
    cnt_nxt   = cnt_p0;
    done_nxt  = 1'b0;
    unique case (state_p0)
      IDLE: begin
        if (fire) begin
          shreg_nxt = bus.in_data;
          cnt_nxt   = CNT_LOAD;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.serial_en) begin
          if (!last_bit) begin
            shreg_nxt = {shreg_p0[DEPTH-2:0], 1'b0};
            cnt_nxt   = cnt_p0 - 1'b1;
          end else begin
            // last bit leaves now; a waiting word loads on this same edge
            done_nxt = 1'b1;
            if (fire) begin
              shreg_nxt = bus.in_data;
              cnt_nxt   = CNT_LOAD;
            end else begin
              shreg_nxt = '0;
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state / shift register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0 <= IDLE;
      shreg_p0 <= '0;
      cnt_p0   <= '0;
      done_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      shreg_p0 <= shreg_nxt;
      cnt_p0   <= cnt_nxt;
      done_p0  <= done_nxt;
    end
  end

endmodule
